sprite_rom_arbiter: RTL

Shares one synchronous sprite/palette ROM among the three on-screen object renderers: ball, wall block, and background. Each renderer raises a read request with an address. The arbiter grants one request per cycle, drives the ROM port, and returns the ROM word tagged to the winning requester after a fixed latency. It sits between the object renderers and the color mapping stage, in the VGA pixel clock domain.

---
 rtl/sprite_rom_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Shares one sync sprite/palette ROM among ball/wall/background renderers; define ROUND_ROBIN_EN for rotating priority.
// Grant is combinational, return is registered ROM_LAT+2 cycles after grant; never stalls, no backpressure on returns.
module sprite_rom_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int ROM_LAT  = 2,
  parameter int MAX_WAIT = 7
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] ball_addr,
  input  logic [ADDR_W-1:0] wall_addr,
  input  logic [ADDR_W-1:0] backg_addr,
  output logic [2:0]        gnt,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        rvalid
);

  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

  logic [CW-1:0]     wait_cnt_q [3];
  logic [CW-1:0]     wait_cnt_d [3];
  logic [2:0]        starved;
  logic [2:0]        gnt_raw;
  logic [2:0]        tag_q [ROM_LAT+1];
  logic              rom_rd_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        rvalid_q;

  always_comb begin
    starved = 3'b000;
    for (int i = 0; i < 3; i++) begin
      starved[i] = req[i] && (wait_cnt_q[i] == WAIT_SAT);
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] rr_pick;

  // Rotating order starting at ptr_q; the last winner drops to lowest priority.
  always_comb begin
    rr_pick = 3'b000;
    case (ptr_q)
      2'd1:    rr_pick = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      2'd2:    rr_pick = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: rr_pick = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 2'd1;
    else if (gnt[1]) ptr_d = 2'd2;
    else if (gnt[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    gnt_raw = 3'b000;
    if (starved[0])      gnt_raw = 3'b001;
    else if (starved[1]) gnt_raw = 3'b010;
    else if (starved[2]) gnt_raw = 3'b100;
    else begin
`ifdef ROUND_ROBIN_EN
      gnt_raw = rr_pick;
`else
      if (req[0])      gnt_raw = 3'b001;
      else if (req[1]) gnt_raw = 3'b010;
      else if (req[2]) gnt_raw = 3'b100;
`endif
    end
  end

  // req is don't-care while reset is held, so the grant is masked then.
  assign gnt = Reset_n ? gnt_raw : 3'b000;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wait_cnt_d[i] = '0;
      if (req[i] && !gnt[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_SAT) ? WAIT_SAT : wait_cnt_q[i] + CW'(1);
      end
    end
    rom_addr_d = rom_addr_q;
    if (gnt[0])      rom_addr_d = ball_addr;
    else if (gnt[1]) rom_addr_d = wall_addr;
    else if (gnt[2]) rom_addr_d = backg_addr;
    rdata_d = rdata_q;
    if (|tag_q[ROM_LAT]) rdata_d = rom_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) wait_cnt_q[i] <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= 3'b000;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) wait_cnt_q[i] <= wait_cnt_d[i];
      // Stage 0 lines up with the ROM address cycle; the last stage with rom_data.
      tag_q[0] <= gnt;
      for (int k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
      rom_rd_q   <= |gnt;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= tag_q[ROM_LAT];
    end
  end

  assign rom_rd   = rom_rd_q;
  assign rom_addr = rom_addr_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

endmodule
